// File: rtl/enabled_shift_register.sv
// enabled_shift_register: clock-enabled universal shift register with a counted multi-shift sequencer
module enabled_shift_register #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             s_in_l,
  input  logic             s_in_r,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic dir, dir_n, rot_l, rot_n, s_out_n, done_n, sh_rot;
  logic [WIDTH-1:0] q_n, right_q, left_q;
  always_comb begin
    sh_rot = state == SHIFT ? rot_l : rot;
    right_q = {sh_rot ? q[0] : s_in_r, q[WIDTH-1:1]};
    left_q = {q[WIDTH-2:0], sh_rot ? q[WIDTH-1] : s_in_l};
    state_n = state;
    cnt_n = cnt;
    dir_n = dir;
    rot_n = rot_l;
    q_n = q;
    s_out_n = s_out;
    done_n = 1'b0;
    if (enb) begin
      if (state == SHIFT) begin
        q_n = dir ? left_q : right_q;
        s_out_n = dir ? q[WIDTH-1] : q[0];
        cnt_n = cnt - 1'b1;
        state_n = cnt == 1 ? IDLE : SHIFT;
        done_n = cnt == 1;
      end else if (start && (mode[1] ^ mode[0])) begin
        done_n = amount == '0;
        state_n = amount == '0 ? IDLE : SHIFT;
        cnt_n = amount;
        dir_n = mode[1];
        rot_n = rot;
      end else if (mode == 2'b11) begin
        q_n = d;
      end else if (mode != 2'b00) begin
        q_n = mode[1] ? left_q : right_q;
        s_out_n = mode[1] ? q[WIDTH-1] : q[0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      rot_l <= 1'b0;
      q <= '0;
      s_out <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dir <= dir_n;
      rot_l <= rot_n;
      q <= q_n;
      s_out <= s_out_n;
      done <= done_n;
    end
  end
  assign busy = state == SHIFT;
endmodule

// File: doc/enabled_shift_register.md
Name: enabled_shift_register

Overview:
- Parameterised universal shift register, one stage downstream of the clock-enable stage; consumes that stage's enable as a synchronous clock enable on the single system clock, with no gated clock.
- Supports hold, serial shift right/left (serial-in or rotate) and parallel load.
- Built-in sequencer shifts a programmed number of positions and reports busy/done.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 3, width of shift-amount input and internal down-counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
enb  input  1  synchronous enable; state advances only on clk edges with enb=1
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
rot  input  1  1: rotate (wrap-around bit), 0: use serial input
s_in_l  input  1  serial bit entering LSB on left shift
s_in_r  input  1  serial bit entering MSB on right shift
d  input  WIDTH  parallel load data
start  input  1  launch multi-position shift sequence
amount  input  CNT_W  number of positions for sequence
q  output  WIDTH  register contents (registered)
s_out  output  1  last bit shifted out (registered)
busy  output  1  sequence in progress
done  output  1  one-cycle pulse at sequence completion

Behaviour:
- One clock domain (clk); reset synchronous, active-high, checked before enb.
- rst=1 at edge: q=0, s_out=0, busy=0, done=0, counter=0, FSM=IDLE. Aborts any sequence; no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE, enb=1, start=0, per mode:
  - 00: q, s_out unchanged.
  - 01: q <= {rot ? q[0] : s_in_r, q[WIDTH-1:1]}; s_out <= q[0].
  - 10: q <= {q[WIDTH-2:0], rot ? q[WIDTH-1] : s_in_l}; s_out <= q[WIDTH-1].
  - 11: q <= d; s_out unchanged.
- IDLE, enb=1, start=1, mode in {01,10}:
  - amount=0: no shift; done=1 for next cycle; stay IDLE.
  - amount>0: latch direction (mode) and rot; counter <= amount; q not modified on this edge; busy=1; go to SHIFT.
- start with mode 00/11 is ignored; the mode operation executes normally.
- SHIFT, enb=1:
  - One shift in latched direction/rot; serial inputs sampled live; s_out updated as above; counter decrements.
  - On the edge where the counter goes 1->0: busy=0, done=1, go to IDLE.
- SHIFT: mode, d, start and current rot are ignored. A start asserted while busy is dropped, not queued.
- enb=0 in any state: q, s_out, counter, FSM frozen.
- done rule: done clears on the next clk edge regardless of enb. The done=1 edge is an IDLE edge and performs the IDLE operation if enb=1.
- Timing: start accepted at edge k with amount=N and enb continuously high:
  - shifts on edges k+1..k+N;
  - busy high from k to k+N;
  - done high from k+N to k+N+1.
  - Each enb=0 cycle during SHIFT extends this by one cycle.
- Counter never underflows; amount max = 2^CNT_W-1.

Test Plan:
1. Reset: rst=1, enb=1, mode=11, d=1111 for one edge -> q=0000, s_out=0, busy=0, done=0.
2. Load and enable gating:
   - enb=1, mode=11, d=1011 -> q=1011.
   - Then enb=0, mode=11, d=0000 for 3 edges -> q stays 1011.
3. Single shifts from q=1011:
   - mode=10, rot=0, s_in_l=1 -> q=0111, s_out=1.
   - Reload 1011; mode=01, rot=1 -> q=1101, s_out=1.
4. Sequence: q=1000, mode=01, rot=1, start=1, amount=3, enb=1 ->
   - busy=1 after the start edge;
   - q=0100, 0010, 0001 on the next 3 edges;
   - busy=0 and done=1 for exactly one cycle after the third shift;
   - q holds 0001 with mode=00.
5. Enable stall: repeat scenario 4 with enb=0 for 2 cycles after the first shift -> q holds 0100 during the stall; busy lasts 5 cycles; final q=0001; single done pulse; mode=11 and start during busy have no effect.
6. Abort and zero:
   - rst=1 after the first shift of an amount=3 sequence -> q=0000, busy=0, no done.
   - Then q=0110, start=1, amount=0, mode=10 -> done pulses once, busy stays 0, q=0110.
